csr_timer_intc: RTL and testbench

//  Parametrised multi-channel timer and interrupt-pending unit behind the CSR access port.

---
 rtl/csr_timer_pkg.sv | 33 +++
 rtl/csr_timer_ch.sv | 66 ++++++
 rtl/csr_timer_intc.sv | 159 +++++++++++++++
 tb/tb_csr_timer_intc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_pkg.sv
// Shared constants for the multi-channel CSR timer / interrupt-pending unit.
package csr_timer_pkg;

    localparam int unsigned CSR_NUM_W = 14;
    localparam int unsigned CH_STRIDE = 4;

    // Offsets inside one channel's four-entry window
    localparam logic [1:0] OFS_TCFG    = 2'd0;
    localparam logic [1:0] OFS_TVAL    = 2'd1;
    localparam logic [1:0] OFS_TICLR   = 2'd2;

    // Offsets relative to the first address past the last channel (4*N_CH)
    localparam logic [1:0] OFS_IE      = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_SCNT_LO = 2'd2;
    localparam logic [1:0] OFS_SCNT_HI = 2'd3;

    localparam int unsigned TCFG_EN     = 0;
    localparam int unsigned TCFG_PERIOD = 1;
    localparam int unsigned TICLR_CLR   = 0;

    typedef enum logic [2:0] {
        SelNone,
        SelTcfg,
        SelTval,
        SelTiclr,
        SelIe,
        SelStatus,
        SelScntLo,
        SelScntHi
    } csr_sel_e;

endpackage

// File: rtl/csr_timer_ch.sv
// One timer channel: TCFG register, down-counter and sticky pending bit.
module csr_timer_ch
    import csr_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we_tcfg,
    input  logic             we_ticlr,
    input  logic [CNT_W-1:0] wmask,
    input  logic [CNT_W-1:0] wvalue,
    output logic [CNT_W-1:0] tcfg,
    output logic [CNT_W-1:0] tval,
    output logic             pend
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] r_tcfg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;

    logic [CNT_W-1:0] w_tcfg_new;
    logic [CNT_W-1:0] w_tcfg_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_set;
    logic             w_clr;

    assign w_tcfg_new = (wmask & wvalue) | (~wmask & r_tcfg);
    assign w_tcfg_d   = we_tcfg ? w_tcfg_new : r_tcfg;

    always_comb begin
        w_cnt_d = r_cnt;
        if (we_tcfg && w_tcfg_new[TCFG_EN]) begin
            w_cnt_d = {w_tcfg_new[CNT_W-1:2], 2'b00};
        end else if (r_tcfg[TCFG_EN] && (r_cnt != '1)) begin
            // One-shot channels fall through 0 -> all-ones and park there
            if ((r_cnt == '0) && r_tcfg[TCFG_PERIOD]) begin
                w_cnt_d = {r_tcfg[CNT_W-1:2], 2'b00};
            end else begin
                w_cnt_d = r_cnt - CntOne;
            end
        end
    end

    assign w_set = r_tcfg[TCFG_EN] && (r_cnt == '0);
    assign w_clr = we_ticlr && wmask[TICLR_CLR] && wvalue[TICLR_CLR];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcfg <= '0;
            r_cnt  <= '1;
            r_pend <= 1'b0;
        end else begin
            r_tcfg <= w_tcfg_d;
            r_cnt  <= w_cnt_d;
            r_pend <= w_set | (r_pend & ~w_clr);
        end
    end

    assign tcfg = r_tcfg;
    assign tval = r_cnt;
    assign pend = r_pend;

endmodule

// File: rtl/csr_timer_intc.sv
// N-channel timer plus interrupt-pending/enable unit on the CSR port.
// Define STABLE_COUNTER_EN to add a read-only 64-bit free-running counter.
module csr_timer_intc
    import csr_timer_pkg::*;
#(
    parameter int unsigned          N_CH     = 4,
    parameter int unsigned          CNT_W    = 32,
    parameter int unsigned          HW_INT_W = 8,
    parameter logic [CSR_NUM_W-1:0] CSR_BASE = 14'h60
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     csr_re,
    input  logic [CSR_NUM_W-1:0]     csr_num,
    output logic [31:0]              csr_rvalue,
    input  logic                     csr_we,
    input  logic [31:0]              csr_wmask,
    input  logic [31:0]              csr_wvalue,
    input  logic [HW_INT_W-1:0]      hw_int_in,
    output logic [N_CH+HW_INT_W-1:0] pend_vec,
    output logic                     irq,
    output logic [3:0]               irq_id
);

    localparam int unsigned          PW     = N_CH + HW_INT_W;
    localparam logic [CSR_NUM_W-1:0] CH_END = CSR_NUM_W'(CH_STRIDE * N_CH);

    logic [CSR_NUM_W-1:0] w_ofs;
    csr_sel_e             w_sel;
    logic [2:0]           w_ch;

    logic [N_CH-1:0]      w_we_tcfg;
    logic [N_CH-1:0]      w_we_ticlr;
    logic [CNT_W-1:0]     w_tcfg [N_CH];
    logic [CNT_W-1:0]     w_tval [N_CH];
    logic [N_CH-1:0]      w_tpend;

    logic [PW-1:0]        r_ie;
    logic [HW_INT_W-1:0]  r_hw;
    logic                 r_irq;
    logic [3:0]           r_irq_id;

    logic [PW-1:0]        w_pend_vec;
    logic [PW-1:0]        w_active;
    logic [3:0]           w_irq_id;
    logic [31:0]          w_rdata;

    assign w_ofs = csr_num - CSR_BASE;

    always_comb begin
        w_sel = SelNone;
        w_ch  = '0;
        if (w_ofs < CH_END) begin
            w_ch = w_ofs[4:2];
            case (w_ofs[1:0])
                OFS_TCFG:  w_sel = SelTcfg;
                OFS_TVAL:  w_sel = SelTval;
                OFS_TICLR: w_sel = SelTiclr;
                default:   w_sel = SelNone;
            endcase
        end else if (w_ofs[CSR_NUM_W-1:2] == CH_END[CSR_NUM_W-1:2]) begin
            case (w_ofs[1:0])
                OFS_IE:      w_sel = SelIe;
                OFS_STATUS:  w_sel = SelStatus;
`ifdef STABLE_COUNTER_EN
                OFS_SCNT_LO: w_sel = SelScntLo;
                OFS_SCNT_HI: w_sel = SelScntHi;
`endif
                default:     w_sel = SelNone;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_we_tcfg[i]  = csr_we && (w_sel == SelTcfg) && (w_ch == 3'(i));
        assign w_we_ticlr[i] = csr_we && (w_sel == SelTiclr) && (w_ch == 3'(i));

        csr_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .we_tcfg  (w_we_tcfg[i]),
            .we_ticlr (w_we_ticlr[i]),
            .wmask    (csr_wmask[CNT_W-1:0]),
            .wvalue   (csr_wvalue[CNT_W-1:0]),
            .tcfg     (w_tcfg[i]),
            .tval     (w_tval[i]),
            .pend     (w_tpend[i])
        );
    end

    assign w_pend_vec = {r_hw, w_tpend};
    assign w_active   = w_pend_vec & r_ie;

    // Lowest set index wins
    always_comb begin
        w_irq_id = '0;
        for (int k = PW - 1; k >= 0; k--) begin
            if (w_active[k]) begin
                w_irq_id = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ie     <= '0;
            r_hw     <= '0;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            if (csr_we && (w_sel == SelIe)) begin
                r_ie <= (csr_wmask[PW-1:0] & csr_wvalue[PW-1:0]) | (~csr_wmask[PW-1:0] & r_ie);
            end
            r_hw     <= hw_int_in;
            r_irq    <= |w_active;
            r_irq_id <= w_irq_id;
        end
    end

`ifdef STABLE_COUNTER_EN
    logic [63:0] r_scnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scnt <= '0;
        end else begin
            r_scnt <= r_scnt + 64'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SelTcfg, SelTval: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (w_ch == 3'(k)) begin
                        w_rdata[CNT_W-1:0] = (w_sel == SelTcfg) ? w_tcfg[k] : w_tval[k];
                    end
                end
            end
            SelIe:     w_rdata[PW-1:0] = r_ie;
            SelStatus: w_rdata[PW-1:0] = w_pend_vec;
`ifdef STABLE_COUNTER_EN
            SelScntLo: w_rdata = r_scnt[31:0];
            SelScntHi: w_rdata = r_scnt[63:32];
`endif
            default:   w_rdata = '0;
        endcase
    end

    assign csr_rvalue = csr_re ? w_rdata : 32'd0;
    assign pend_vec   = w_pend_vec;
    assign irq        = r_irq;
    assign irq_id     = r_irq_id;

endmodule

// File: tb/tb_csr_timer_intc.sv
// Directed bench for csr_timer_intc (N_CH=4, CNT_W=32, HW_INT_W=8, base 0x60).
module tb_csr_timer_intc;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [7:0]  hw_int_in;
    logic [11:0] pend_vec;
    logic        irq;
    logic [3:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_timer_intc #(
        .N_CH     (4),
        .CNT_W    (32),
        .HW_INT_W (8),
        .CSR_BASE (14'h60)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_re     (csr_re),
        .csr_num    (csr_num),
        .csr_rvalue (csr_rvalue),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .hw_int_in  (hw_int_in),
        .pend_vec   (pend_vec),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        csr_re  = 1'b1;
        csr_num = a;
        #1;
        d      = csr_rvalue;
        csr_re = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_we     = 1'b1;
        csr_num    = a;
        csr_wmask  = m;
        csr_wvalue = v;
        step();
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
    endtask

    logic [31:0] d;
    logic [31:0] s_a;
    logic [31:0] s_b;

    initial begin
        resetn     = 1'b0;
        csr_re     = 1'b0;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        hw_int_in  = '0;
        #12;
        resetn = 1'b1;
        step();

        // Reset state
        rd(14'h61, d); chk("rst_tval0", d, 32'hFFFF_FFFF);
        rd(14'h60, d); chk("rst_tcfg0", d, 32'h0);
        rd(14'h70, d); chk("rst_ie", d, 32'h0);
        rd(14'h71, d); chk("rst_status", d, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_irq_id", {28'b0, irq_id}, 32'd0);
        csr_num = 14'h61;
        #1;
        chk("re0_reads_zero", csr_rvalue, 32'h0);
        rd(14'h63, d); chk("unmapped_read", d, 32'h0);

        // One-shot channel 0, initval 5
        wr(14'h70, 32'hFFFF_FFFF, 32'h1);
        wr(14'h60, 32'hFFFF_FFFF, 32'h15);
        for (int v = 20; v >= 0; v--) begin
            rd(14'h61, d); chk("oneshot_tval0", d, 32'(v));
            rd(14'h71, d); chk("oneshot_no_pend", d, 32'h0);
            chk("oneshot_no_irq", {31'b0, irq}, 32'd0);
            step();
        end
        rd(14'h61, d); chk("oneshot_wrap", d, 32'hFFFF_FFFF);
        rd(14'h71, d); chk("oneshot_pend0", d, 32'h1);
        chk("oneshot_irq_lag", {31'b0, irq}, 32'd0);
        step();
        chk("oneshot_irq", {31'b0, irq}, 32'd1);
        chk("oneshot_irq_id", {28'b0, irq_id}, 32'd0);
        step();
        rd(14'h61, d); chk("oneshot_hold", d, 32'hFFFF_FFFF);
        rd(14'h62, d); chk("ticlr_reads_zero", d, 32'h0);
        wr(14'h62, 32'hFFFF_FFFF, 32'h1);
        rd(14'h71, d); chk("ticlr0_pend", d, 32'h0);
        chk("ticlr0_irq_still", {31'b0, irq}, 32'd1);
        step();
        chk("ticlr0_irq_drop", {31'b0, irq}, 32'd0);

        // Periodic channel 1, initval 2
        wr(14'h64, 32'hFFFF_FFFF, 32'h0B);
        for (int v = 8; v >= 0; v--) begin
            rd(14'h65, d); chk("periodic_tval1_a", d, 32'(v));
            step();
        end
        rd(14'h71, d); chk("periodic_pend1", d, 32'h2);
        for (int v = 8; v >= 1; v--) begin
            rd(14'h65, d); chk("periodic_tval1_b", d, 32'(v));
            step();
        end
        rd(14'h65, d); chk("periodic_tval1_zero", d, 32'h0);
        wr(14'h66, 32'hFFFF_FFFF, 32'h1);
        rd(14'h71, d); chk("set_wins", d, 32'h2);
        rd(14'h65, d); chk("periodic_reload", d, 32'h8);
        wr(14'h66, 32'hFFFF_FFFF, 32'h1);
        rd(14'h71, d); chk("ticlr1_pend", d, 32'h0);
        rd(14'h65, d); chk("periodic_tval1_7", d, 32'h7);
        wr(14'h64, 32'hFFFF_FFFF, 32'h0);
        rd(14'h65, d); chk("disable_freeze_a", d, 32'h6);
        step();
        rd(14'h65, d); chk("disable_freeze_b", d, 32'h6);

        // Priority: pend_2 (initval 0 periodic) vs hw bit 0 (index 4)
        hw_int_in = 8'h01;
        wr(14'h68, 32'hFFFF_FFFF, 32'h3);
        wr(14'h70, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h70, d); chk("ie_width", d, 32'hFFF);
        rd(14'h71, d); chk("prio_status", d, 32'h14);
        chk("prio_irq_lag", {31'b0, irq}, 32'd0);
        step();
        chk("prio_irq", {31'b0, irq}, 32'd1);
        chk("prio_irq_id2", {28'b0, irq_id}, 32'd2);
        wr(14'h70, 32'h4, 32'h0);
        rd(14'h70, d); chk("ie_masked_clear", d, 32'hFFB);
        step();
        chk("prio_irq_id4", {28'b0, irq_id}, 32'd4);
        chk("prio_irq_on", {31'b0, irq}, 32'd1);
        hw_int_in = 8'h00;
        step();
        rd(14'h71, d); chk("hw_level", d, 32'h04);
        step();
        chk("prio_irq_off", {31'b0, irq}, 32'd0);
        wr(14'h68, 32'hFFFF_FFFF, 32'h0);
        wr(14'h6A, 32'hFFFF_FFFF, 32'h1);
        rd(14'h71, d); chk("ch2_cleared", d, 32'h0);

        // Masked TCFG write clears only en
        wr(14'h60, 32'hFFFF_FFFF, 32'h15);
        step();
        step();
        rd(14'h61, d); chk("masked_pre", d, 32'd18);
        wr(14'h60, 32'h1, 32'h0);
        rd(14'h60, d); chk("masked_tcfg", d, 32'h14);
        rd(14'h61, d); chk("masked_tval_a", d, 32'd17);
        step();
        rd(14'h61, d); chk("masked_tval_b", d, 32'd17);

        // Stable counter
        step();
        rd(14'h72, s_a);
        repeat (10) step();
        rd(14'h72, s_b);
        rd(14'h73, d);
`ifdef STABLE_COUNTER_EN
        chk("scnt_diff", s_b - s_a, 32'd10);
        chk("scnt_hi", d, 32'h0);
`else
        chk("scnt_lo_a", s_a, 32'h0);
        chk("scnt_lo_b", s_b, 32'h0);
        chk("scnt_hi", d, 32'h0);
`endif

        // Asynchronous reset mid-cycle with irq active and channel 0 counting
        wr(14'h6C, 32'hFFFF_FFFF, 32'h3);
        wr(14'h60, 32'hFFFF_FFFF, 32'h15);
        step();
        chk("pre_rst_irq", {31'b0, irq}, 32'd1);
        chk("pre_rst_irq_id", {28'b0, irq_id}, 32'd3);
        rd(14'h61, d); chk("pre_rst_tval0", d, 32'd19);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_irq", {31'b0, irq}, 32'd0);
        chk("arst_irq_id", {28'b0, irq_id}, 32'd0);
        rd(14'h61, d); chk("arst_tval0", d, 32'hFFFF_FFFF);
        rd(14'h71, d); chk("arst_status", d, 32'h0);
        #3;
        resetn = 1'b1;
        step();
        rd(14'h60, d); chk("post_rst_tcfg0", d, 32'h0);
        step();
        rd(14'h61, d); chk("post_rst_tval0", d, 32'hFFFF_FFFF);
        chk("post_rst_irq", {31'b0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
